exec_core: RTL and testbench

//  Single-cycle MIPS-subset decode/execute/memory core: instruction decoder, 32-bit ALU and data memory.

---
 rtl/exec_core.sv | 184 ++++++++++++++++++
 tb/tb_exec_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_core.sv
// exec_core: single-cycle MIPS-subset decode / ALU / data-memory slice.
// Decode, ALU and memory read are purely combinational; only the data
// memory write is clocked. Reset suppresses every architectural write.
module exec_core #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [27:0] jImm,
  output logic        regDst,
  output logic        regWrEn,
  output logic        extSel,
  output logic        aluSrcB,
  output logic [2:0]  aluCommand,
  output logic        memWrEn,
  output logic [1:0]  writebackSrc,
  output logic [1:0]  pcSrc,
  output logic [31:0] aluResult,
  output logic        aluZero,
  output logic        carryout,
  output logic        overflow,
  output logic [31:0] memReadData
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic        reg_wr_s;
  logic        mem_wr_s;
  logic [1:0]  pc_src_s;
  logic        is_bne_s;
  logic        is_jal_s;
  logic [31:0] ext_imm_s;
  logic [31:0] op_b_s;
  logic [32:0] add_full_s;
  logic [32:0] sub_full_s;
  logic        add_ovf_s;
  logic        sub_ovf_s;
  logic        slt_s;
  logic [AW-1:0] mem_idx_s;
  logic [31:0] mem_q [MEM_WORDS];

  assign opcode_s = instruction[31:26];
  assign funct_s  = instruction[5:0];
  assign rs       = instruction[25:21];
  assign rt       = instruction[20:16];
  assign rd       = is_jal_s ? 5'd31 : instruction[15:11];
  assign imm      = instruction[15:0];
  assign jImm     = {instruction[25:0], 2'b00};

  // Instruction decode: raw control before reset gating and branch resolution.
  always_comb begin
    regDst       = 1'b0;
    reg_wr_s     = 1'b0;
    extSel       = 1'b0;
    aluSrcB      = 1'b0;
    aluCommand   = ALU_ADD;
    mem_wr_s     = 1'b0;
    writebackSrc = 2'd0;
    pc_src_s     = 2'd0;
    is_bne_s     = 1'b0;
    is_jal_s     = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD: begin reg_wr_s = 1'b1; aluCommand = ALU_ADD; end
          FN_SUB: begin reg_wr_s = 1'b1; aluCommand = ALU_SUB; end
          FN_SLT: begin reg_wr_s = 1'b1; aluCommand = ALU_SLT; end
          FN_JR:  begin pc_src_s = 2'd1; end
          default: begin reg_wr_s = 1'b0; end
        endcase
      end
      OP_ADDI: begin
        regDst = 1'b1; reg_wr_s = 1'b1; aluSrcB = 1'b1; extSel = 1'b1;
        aluCommand = ALU_ADD;
      end
      OP_XORI: begin
        regDst = 1'b1; reg_wr_s = 1'b1; aluSrcB = 1'b1; extSel = 1'b0;
        aluCommand = ALU_XOR;
      end
      OP_LW: begin
        regDst = 1'b1; reg_wr_s = 1'b1; aluSrcB = 1'b1; extSel = 1'b1;
        aluCommand = ALU_ADD; writebackSrc = 2'd1;
      end
      OP_SW: begin
        mem_wr_s = 1'b1; aluSrcB = 1'b1; extSel = 1'b1; aluCommand = ALU_ADD;
      end
      OP_BNE: begin
        aluCommand = ALU_SUB; extSel = 1'b1; is_bne_s = 1'b1;
      end
      OP_J: begin
        pc_src_s = 2'd2;
      end
      OP_JAL: begin
        pc_src_s = 2'd2; reg_wr_s = 1'b1; is_jal_s = 1'b1; writebackSrc = 2'd2;
      end
      default: begin
        reg_wr_s = 1'b0;
      end
    endcase
  end

  // Reset forces all architectural writes and redirects off; BNE resolves on aluZero.
  assign regWrEn = reg_wr_s & ~reset;
  assign memWrEn = mem_wr_s & ~reset;
  assign pcSrc   = reset ? 2'd0 :
                   (is_bne_s ? (aluZero ? 2'd0 : 2'd3) : pc_src_s);

  assign ext_imm_s  = extSel ? {{16{imm[15]}}, imm} : {16'd0, imm};
  assign op_b_s     = aluSrcB ? ext_imm_s : readData2;
  assign add_full_s = {1'b0, readData1} + {1'b0, op_b_s};
  assign sub_full_s = {1'b0, readData1} + {1'b0, ~op_b_s} + 33'd1;
  assign add_ovf_s  = (readData1[31] == op_b_s[31]) && (add_full_s[31] != readData1[31]);
  assign sub_ovf_s  = (readData1[31] != op_b_s[31]) && (sub_full_s[31] != readData1[31]);
  // Sign of the true difference: corrected by the overflow flag.
  assign slt_s      = sub_full_s[31] ^ sub_ovf_s;

  // ALU datapath: result plus carry/overflow flags, flags only meaningful for ADD/SUB.
  always_comb begin
    aluResult = add_full_s[31:0];
    carryout  = 1'b0;
    overflow  = 1'b0;
    case (aluCommand)
      ALU_ADD: begin
        aluResult = add_full_s[31:0]; carryout = add_full_s[32]; overflow = add_ovf_s;
      end
      ALU_SUB: begin
        aluResult = sub_full_s[31:0]; carryout = sub_full_s[32]; overflow = sub_ovf_s;
      end
      ALU_XOR:  aluResult = readData1 ^ op_b_s;
      ALU_SLT:  aluResult = {31'd0, slt_s};
      ALU_AND:  aluResult = readData1 & op_b_s;
      ALU_NAND: aluResult = ~(readData1 & op_b_s);
      ALU_NOR:  aluResult = ~(readData1 | op_b_s);
      ALU_OR:   aluResult = readData1 | op_b_s;
      default:  aluResult = add_full_s[31:0];
    endcase
  end

  assign aluZero = (aluResult == 32'd0);

  // Word index: byte offset dropped, upper address bits ignored so addresses wrap.
  assign mem_idx_s   = aluResult[AW+1:2];
  assign memReadData = mem_q[mem_idx_s];

  // Data memory write port; memWrEn already carries the reset suppression.
  always_ff @(posedge clk) begin
    if (memWrEn) begin
      mem_q[mem_idx_s] <= readData2;
    end
  end

endmodule

// File: tb/tb_exec_core.sv
// Scoreboard bench for exec_core: each drive pushes expected values,
// which are popped and compared once the combinational outputs settle.
module tb_exec_core;

  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction, readData1, readData2;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [27:0] jImm;
  logic        regDst, regWrEn, extSel, aluSrcB, memWrEn;
  logic [2:0]  aluCommand;
  logic [1:0]  writebackSrc, pcSrc;
  logic [31:0] aluResult, memReadData;
  logic        aluZero, carryout, overflow;

  exec_core #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .readData1(readData1), .readData2(readData2),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .jImm(jImm),
    .regDst(regDst), .regWrEn(regWrEn), .extSel(extSel), .aluSrcB(aluSrcB),
    .aluCommand(aluCommand), .memWrEn(memWrEn), .writebackSrc(writebackSrc),
    .pcSrc(pcSrc), .aluResult(aluResult), .aluZero(aluZero),
    .carryout(carryout), .overflow(overflow), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  typedef enum int {S_RES, S_ZERO, S_CARRY, S_OVF, S_REGWR, S_MEMWR, S_PCSRC,
                    S_WB, S_REGDST, S_RS, S_RT, S_RD, S_MRD, S_EXTSEL, S_SRCB,
                    S_JIMM, S_IMM} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] observe(input sel_e sel);
    case (sel)
      S_RES:    return aluResult;
      S_ZERO:   return {31'd0, aluZero};
      S_CARRY:  return {31'd0, carryout};
      S_OVF:    return {31'd0, overflow};
      S_REGWR:  return {31'd0, regWrEn};
      S_MEMWR:  return {31'd0, memWrEn};
      S_PCSRC:  return {30'd0, pcSrc};
      S_WB:     return {30'd0, writebackSrc};
      S_REGDST: return {31'd0, regDst};
      S_RS:     return {27'd0, rs};
      S_RT:     return {27'd0, rt};
      S_RD:     return {27'd0, rd};
      S_MRD:    return memReadData;
      S_EXTSEL: return {31'd0, extSel};
      S_SRCB:   return {31'd0, aluSrcB};
      S_JIMM:   return {4'd0, jImm};
      S_IMM:    return {16'd0, imm};
      default:  return 32'd0;
    endcase
  endfunction

  task automatic push(input string tag, input sel_e sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic rst);
    @(negedge clk);
    instruction = ins; readData1 = a; readData2 = b; reset = rst;
  endtask

  task automatic drain;
    exp_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    instruction = 32'd0; readData1 = 32'd0; readData2 = 32'd0; reset = 1'b1;

    // Reset: writes and redirects forced off, ALU still live.
    drive(enc_r(5'd4, 5'd5, 5'd6, 6'h20), 32'd5, 32'd7, 1'b1);
    push("rst_regwr", S_REGWR, 32'd0); push("rst_memwr", S_MEMWR, 32'd0);
    push("rst_pcsrc", S_PCSRC, 32'd0); push("rst_res", S_RES, 32'd12);
    drain();
    drive(enc_r(5'd4, 5'd0, 5'd0, 6'h08), 32'h100, 32'd0, 1'b1);
    push("rst_jr_pcsrc", S_PCSRC, 32'd0);
    drain();

    // ADD 5+7
    drive(enc_r(5'd4, 5'd5, 5'd6, 6'h20), 32'd5, 32'd7, 1'b0);
    push("add_res", S_RES, 32'd12); push("add_regwr", S_REGWR, 32'd1);
    push("add_regdst", S_REGDST, 32'd0); push("add_wb", S_WB, 32'd0);
    push("add_rs", S_RS, 32'd4); push("add_rt", S_RT, 32'd5); push("add_rd", S_RD, 32'd6);
    push("add_carry", S_CARRY, 32'd0); push("add_zero", S_ZERO, 32'd0);
    push("add_srcb", S_SRCB, 32'd0);
    drain();

    // SUB A=B
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h22), 32'd9, 32'd9, 1'b0);
    push("sub_res", S_RES, 32'd0); push("sub_zero", S_ZERO, 32'd1);
    push("sub_carry", S_CARRY, 32'd1); push("sub_ovf", S_OVF, 32'd0);
    drain();

    // SLT cases, including ones where A-B overflows
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'h80000000, 32'd1, 1'b0);
    push("slt_neg", S_RES, 32'd1); push("slt_carry", S_CARRY, 32'd0);
    drain();
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'd5, 32'h80000000, 1'b0);
    push("slt_ovf_pos", S_RES, 32'd0);
    drain();
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
    push("slt_max_m1", S_RES, 32'd0);
    drain();
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0);
    push("slt_m2_m1", S_RES, 32'd1);
    drain();

    // ADD overflow and carry boundaries
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFFFFFF, 32'd1, 1'b0);
    push("addovf_res", S_RES, 32'h80000000); push("addovf_ovf", S_OVF, 32'd1);
    push("addovf_carry", S_CARRY, 32'd0);
    drain();
    drive(enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'hFFFFFFFF, 32'd1, 1'b0);
    push("addcy_res", S_RES, 32'd0); push("addcy_carry", S_CARRY, 32'd1);
    push("addcy_ovf", S_OVF, 32'd0); push("addcy_zero", S_ZERO, 32'd1);
    drain();

    // XORI zero-extends, ADDI sign-extends
    drive(enc_i(6'h0E, 5'd1, 5'd2, 16'hFFFF), 32'd0, 32'h55555555, 1'b0);
    push("xori_res", S_RES, 32'h0000FFFF); push("xori_ext", S_EXTSEL, 32'd0);
    push("xori_srcb", S_SRCB, 32'd1); push("xori_regdst", S_REGDST, 32'd1);
    push("xori_regwr", S_REGWR, 32'd1); push("xori_imm", S_IMM, 32'h0000FFFF);
    drain();
    drive(enc_i(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd1, 32'd0, 1'b0);
    push("addi_res", S_RES, 32'd0); push("addi_ext", S_EXTSEL, 32'd1);
    push("addi_ovf", S_OVF, 32'd0);
    drain();

    // SW then LW through the same word, with aliasing and byte offset
    drive(enc_i(6'h2B, 5'd1, 5'd2, 16'd8), 32'd0, 32'hDEADBEEF, 1'b0);
    push("sw_res", S_RES, 32'd8); push("sw_memwr", S_MEMWR, 32'd1);
    push("sw_regwr", S_REGWR, 32'd0); push("sw_pcsrc", S_PCSRC, 32'd0);
    drain();
    drive(enc_i(6'h23, 5'd1, 5'd3, 16'd8), 32'd0, 32'd0, 1'b0);
    push("lw_mrd", S_MRD, 32'hDEADBEEF); push("lw_wb", S_WB, 32'd1);
    push("lw_regwr", S_REGWR, 32'd1); push("lw_regdst", S_REGDST, 32'd1);
    push("lw_memwr", S_MEMWR, 32'd0);
    drain();
    drive(enc_i(6'h2B, 5'd1, 5'd2, 16'd8), 32'd0, 32'h12345678, 1'b0);
    push("sw_old_mrd", S_MRD, 32'hDEADBEEF);
    drain();
    drive(enc_i(6'h23, 5'd1, 5'd3, 16'd0), 32'd8 + 32'd4 * MEM_WORDS, 32'd0, 1'b0);
    push("lw_alias_mrd", S_MRD, 32'h12345678);
    drain();

    // Store under reset is cancelled
    drive(enc_i(6'h2B, 5'd1, 5'd2, 16'd8), 32'd0, 32'hCAFEF00D, 1'b1);
    push("rst_sw_memwr", S_MEMWR, 32'd0);
    drain();
    drive(enc_i(6'h23, 5'd1, 5'd3, 16'd2), 32'd8, 32'd0, 1'b0);
    push("lw_after_rst_sw", S_MRD, 32'h12345678);
    drain();

    // Branches and jumps
    drive(enc_i(6'h05, 5'd1, 5'd2, 16'd4), 32'd3, 32'd3, 1'b0);
    push("bne_eq_pcsrc", S_PCSRC, 32'd0); push("bne_regwr", S_REGWR, 32'd0);
    push("bne_ext", S_EXTSEL, 32'd1); push("bne_srcb", S_SRCB, 32'd0);
    drain();
    drive(enc_i(6'h05, 5'd1, 5'd2, 16'd4), 32'd3, 32'd4, 1'b0);
    push("bne_ne_pcsrc", S_PCSRC, 32'd3); push("bne_ne_memwr", S_MEMWR, 32'd0);
    drain();
    drive({6'h03, 26'h3ABCDEF}, 32'd0, 32'd0, 1'b0);
    push("jal_pcsrc", S_PCSRC, 32'd2); push("jal_rd", S_RD, 32'd31);
    push("jal_wb", S_WB, 32'd2); push("jal_regwr", S_REGWR, 32'd1);
    push("jal_regdst", S_REGDST, 32'd0); push("jal_jimm", S_JIMM, {4'd0, 26'h3ABCDEF, 2'b00});
    drain();
    drive({6'h02, 26'h0000123}, 32'd0, 32'd0, 1'b0);
    push("j_pcsrc", S_PCSRC, 32'd2); push("j_regwr", S_REGWR, 32'd0);
    drain();
    drive(enc_r(5'd31, 5'd0, 5'd0, 6'h08), 32'h400, 32'd0, 1'b0);
    push("jr_pcsrc", S_PCSRC, 32'd1); push("jr_regwr", S_REGWR, 32'd0);
    push("jr_memwr", S_MEMWR, 32'd0);
    drain();

    // Unknown opcode is a NOP and must not touch memory
    drive(enc_i(6'h3F, 5'd1, 5'd2, 16'd8), 32'd0, 32'h0BADF00D, 1'b0);
    push("nop_regwr", S_REGWR, 32'd0); push("nop_memwr", S_MEMWR, 32'd0);
    push("nop_pcsrc", S_PCSRC, 32'd0);
    drain();
    drive(enc_i(6'h23, 5'd1, 5'd3, 16'd8), 32'd0, 32'd0, 1'b0);
    push("lw_after_nop", S_MRD, 32'h12345678);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
